// File: rtl/usb3_ep_pingpong_ctrl_pkg.sv
// Shared encodings for the ping-pong IN endpoint controller: per-half buffer
// states and read-side FSM states.
package usb3_ep_pingpong_ctrl_pkg;

  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufFull  = 2'd1,
    BufBusy  = 2'd2,
    BufHeld  = 2'd3
  } buf_state_e;

  typedef enum logic [1:0] {
    RIdle = 2'd0,
    RAddr = 2'd1,
    RData = 2'd2
  } rd_state_e;

endpackage

// File: rtl/usb3_ep_buf_state.sv
// Lifecycle tracker for one RAM half: EMPTY -> FULL -> BUSY -> HELD -> EMPTY/FULL.
// The length register is only loaded on commit, so a NAK replays the same length.
module usb3_ep_buf_state
  import usb3_ep_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             commit,
  input  logic [LEN_W-1:0] commit_len,
  input  logic             start,
  input  logic             done,
  input  logic             ack,
  input  logic             nak,
  output buf_state_e       state,
  output logic [LEN_W-1:0] len
);

  buf_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      BufEmpty: begin
        if (commit) begin
          state_d = BufFull;
          len_d   = commit_len;
        end
      end
      BufFull: if (start) state_d = BufBusy;
      BufBusy: if (done) state_d = BufHeld;
      BufHeld: begin
        if (ack) begin
          state_d = BufEmpty;
        end else if (nak) begin
          state_d = BufFull;
        end
      end
      default: state_d = BufEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BufEmpty;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign state = state_q;
  assign len   = len_q;

endmodule

// File: rtl/usb3_ep_pingpong_ctrl.sv
// Ping-pong buffer controller for one USB3 IN endpoint: producer fills the free
// RAM half, the read FSM streams the head half and holds it until ACK/NAK.
module usb3_ep_pingpong_ctrl
  import usb3_ep_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prod_valid,
  input  logic [31:0]       prod_data,
  input  logic              prod_last,
  input  logic              prod_zlp,
  output logic              prod_ready,
  output logic              prod_ovf,
  output logic              cons_avail,
  output logic [LEN_W-1:0]  cons_len,
  input  logic              cons_start,
  output logic              cons_valid,
  output logic [31:0]       cons_data,
  output logic              cons_last,
  output logic              cons_done,
  input  logic              cons_ack,
  input  logic              cons_nak,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wr_adr,
  output logic [31:0]       ram_wr_dat,
  output logic [ADDR_W-1:0] ram_rd_adr,
  input  logic [31:0]       ram_rd_dat
);

  localparam int unsigned IdxW = ADDR_W - 1;

  logic              wr_sel_q;
  logic [IdxW-1:0]   wr_idx_q;
  logic              rd_sel_q;
  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_adr_q, rd_adr_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              done_q, done_d;

  buf_state_e        buf_state [2];
  logic [LEN_W-1:0]  buf_len   [2];

  logic              wr_fire, idx_full, commit_word, commit_zlp, commit;
  logic [LEN_W-1:0]  commit_len;
  buf_state_e        head_state;
  logic [LEN_W-1:0]  head_len;
  logic              start_eff, ack_eff, nak_eff;
  logic [ADDR_W-1:0] rd_adr_next;

  // Write side; outputs are forced low while reset is asserted.
  assign prod_ready  = reset_n & (buf_state[wr_sel_q] == BufEmpty);
  assign wr_fire     = prod_valid & prod_ready;
  assign idx_full    = &wr_idx_q;
  assign commit_word = wr_fire & (prod_last | idx_full);
  assign commit_zlp  = prod_zlp & prod_ready & ~prod_valid;
  assign commit      = commit_word | commit_zlp;
  assign commit_len  = commit_zlp ? '0 : LEN_W'(wr_idx_q) + LEN_W'(1);
  assign prod_ovf    = wr_fire & idx_full & ~prod_last;

  assign ram_we      = wr_fire;
  assign ram_wr_adr  = {wr_sel_q, wr_idx_q};
  assign ram_wr_dat  = reset_n ? prod_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_q <= 1'b0;
      wr_idx_q <= '0;
    end else if (commit) begin
      wr_sel_q <= ~wr_sel_q;
      wr_idx_q <= '0;
    end else if (wr_fire) begin
      wr_idx_q <= wr_idx_q + IdxW'(1);
    end
  end

  // Consumer handshake, always against the head half.
  assign head_state = buf_state[rd_sel_q];
  assign head_len   = buf_len[rd_sel_q];
  assign cons_avail = (head_state == BufFull) & (rd_state_q == RIdle);
  assign cons_len   = cons_avail ? head_len : '0;
  assign start_eff  = cons_start & cons_avail;
  assign ack_eff    = cons_ack & (head_state == BufHeld);
  assign nak_eff    = cons_nak & ~cons_ack & (head_state == BufHeld);

  for (genvar h = 0; h < 2; h++) begin : g_buf
    usb3_ep_buf_state #(
      .LEN_W(LEN_W)
    ) u_buf_state (
      .clk       (clk),
      .reset_n   (reset_n),
      .commit    (commit & (wr_sel_q == 1'(h))),
      .commit_len(commit_len),
      .start     (start_eff & (rd_sel_q == 1'(h))),
      .done      (done_q & (rd_sel_q == 1'(h))),
      .ack       (ack_eff & (rd_sel_q == 1'(h))),
      .nak       (nak_eff & (rd_sel_q == 1'(h))),
      .state     (buf_state[h]),
      .len       (buf_len[h])
    );
  end

  // Address advances within the current half only.
  assign rd_adr_next = {rd_adr_q[ADDR_W-1], rd_adr_q[IdxW-1:0] + IdxW'(1)};

  always_comb begin
    rd_state_d = rd_state_q;
    rd_adr_d   = rd_adr_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = 1'b0;
    cons_valid = 1'b0;
    cons_last  = 1'b0;
    case (rd_state_q)
      RIdle: begin
        if (start_eff) begin
          rd_state_d = RAddr;
          rd_adr_d   = {rd_sel_q, IdxW'(0)};
          rd_cnt_d   = '0;
        end
      end
      RAddr: begin
        if (head_len == '0) begin
          done_d     = 1'b1;
          rd_state_d = RIdle;
        end else begin
          rd_state_d = RData;
          rd_adr_d   = rd_adr_next;
        end
      end
      RData: begin
        cons_valid = 1'b1;
        rd_adr_d   = rd_adr_next;
        rd_cnt_d   = rd_cnt_q + LEN_W'(1);
        if (rd_cnt_q == head_len - LEN_W'(1)) begin
          cons_last  = 1'b1;
          done_d     = 1'b1;
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RIdle;
      rd_adr_q   <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_adr_q   <= rd_adr_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
      if (ack_eff) rd_sel_q <= ~rd_sel_q;
    end
  end

  assign cons_data  = reset_n ? ram_rd_dat : '0;
  assign cons_done  = done_q;
  assign ram_rd_adr = rd_adr_q;

endmodule
